// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RV32I pipeline.
//
// Picks the ALU operands through the forwarding muxes, evaluates the ALU,
// resolves branches/jumps into a fetch redirect, and captures everything the
// memory stage needs into the EX/MEM pipeline register.
//
// Ports:
//   clk, rst             clock (rising edge) and asynchronous active-low reset
//   RegWriteE..Funct3E   control fields of the instruction in EX
//   RD1_E, RD2_E         register-file read data for rs1/rs2
//   Imm_Ext_E            sign-extended immediate
//   RD_E                 destination register
//   PCE, PCPlus4E        PC and PC+4 of the instruction in EX
//   ResultW              writeback result, forwarding source
//   ForwardA_E/B_E       forwarding selects (00/11 RF, 01 WB, 10 MEM)
//   StallM, FlushM       EX/MEM register hold / bubble (hold wins)
//   PCSrcE, PCTargetE    combinational redirect select and address
//   *M outputs           EX/MEM pipeline register contents
module execute_cycle #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            ALUSrcE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            JalrE,
  input  logic [3:0]      ALUControlE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [4:0]      RD_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic            StallM,
  input  logic            FlushM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM
);

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluSltu = 4'b0110;
  localparam logic [3:0] AluSll  = 4'b0111;
  localparam logic [3:0] AluSrl  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;

  localparam logic [1:0] FwdWb  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  localparam logic [2:0] BrEq  = 3'b000;
  localparam logic [2:0] BrNe  = 3'b001;
  localparam logic [2:0] BrLt  = 3'b100;
  localparam logic [2:0] BrGe  = 3'b101;
  localparam logic [2:0] BrLtu = 3'b110;
  localparam logic [2:0] BrGeu = 3'b111;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic [4:0]      shamt;
  logic            branch_cond;
  logic            lt_signed;
  logic            lt_unsigned;
  logic            a_eq_b;

  // Operand selection; path 10 feeds back the registered ALU result.
  always_comb begin
    unique case (ForwardA_E)
      FwdWb:   src_a = ResultW;
      FwdMem:  src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
    unique case (ForwardB_E)
      FwdWb:   fwd_b = ResultW;
      FwdMem:  fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  end

  always_comb begin
    shamt      = src_b[4:0];
    alu_result = '0;
    case (ALUControlE)
      AluAdd:  alu_result = src_a + src_b;
      AluSub:  alu_result = src_a - src_b;
      AluAnd:  alu_result = src_a & src_b;
      AluOr:   alu_result = src_a | src_b;
      AluXor:  alu_result = src_a ^ src_b;
      AluSlt:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      AluSltu: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      AluSll:  alu_result = src_a << shamt;
      AluSrl:  alu_result = src_a >> shamt;
      AluSra:  alu_result = $signed(src_a) >>> shamt;
      default: alu_result = '0;
    endcase
  end

  // Branches compare against the forwarded rs2 value, never the immediate.
  always_comb begin
    a_eq_b      = (src_a == fwd_b);
    lt_signed   = ($signed(src_a) < $signed(fwd_b));
    lt_unsigned = (src_a < fwd_b);
    case (Funct3E)
      BrEq:    branch_cond = a_eq_b;
      BrNe:    branch_cond = !a_eq_b;
      BrLt:    branch_cond = lt_signed;
      BrGe:    branch_cond = !lt_signed;
      BrLtu:   branch_cond = lt_unsigned;
      BrGeu:   branch_cond = !lt_unsigned;
      default: branch_cond = 1'b0;
    endcase
  end

  always_comb begin
    PCSrcE = JumpE | (BranchE & branch_cond);
    if (JalrE) begin
      PCTargetE = (src_a + Imm_Ext_E) & {{(XLEN-1){1'b1}}, 1'b0};
    end else begin
      PCTargetE = PCE + Imm_Ext_E;
    end
  end

  // EX/MEM register: stall holds (and overrides flush), flush inserts a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (StallM) begin
      RegWriteM   <= RegWriteM;
      MemWriteM   <= MemWriteM;
      ResultSrcM  <= ResultSrcM;
      RD_M        <= RD_M;
      PCPlus4M    <= PCPlus4M;
      WriteDataM  <= WriteDataM;
      ALU_ResultM <= ALU_ResultM;
    end else if (FlushM) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwd_b;
      ALU_ResultM <= alu_result;
    end
  end

endmodule
